pll_rst_seq: RTL
================

// Module: pll_rst_seq
// PURPOSE
//  Sequences the clock-management PLL and the system reset after power-up, after a soft restart and after loss of lock.
//  - Pulses the PLL RST, waits for LOCKED, filters it for stability, then releases the synchronous system reset.
//  - Retries on lock timeout; sticks in FAILED once the retry budget is spent.
//  - Sits beside clk_mgmt; runs on the free-running board reference clock, not on the PLL output.
// PARAMETERS
//  PLL_RST_CYCLES       16     cycles pll_rst_o is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES   1024   consecutive synced-lock-high cycles before release (>=1)
//  LOCK_TIMEOUT_CYCLES  65536  max cycles in WAIT_LOCK/STABLE before counting a failed attempt
//  MAX_RETRIES          3      failed attempts allowed before FAILED (>=1)
// PORTS
//  clk_in           in   1   free-running reference clock
//  rst_in           in   1   asynchronous, active-high reset
//  clk_locked_i     in   1   PLL LOCKED, asynchronous to clk_in
//  soft_rst_req_i   in   1   single-cycle restart request
//  pll_rst_o        out  1   PLL RST, active-high
//  sys_rst_o        out  1   system reset, active-high, deasserted synchronously to clk_in
//  ready_o          out  1   high only in RUN
//  fail_o           out  1   high only in FAILED
//  retry_cnt_o      out  $clog2(MAX_RETRIES+1)  failed attempts since last restart
//  lock_loss_cnt_o  out  8   lock losses seen in RUN, saturates at 255
//  state_o          out  3   encoded FSM state, for debug
// BEHAVIOUR
//  - rst_in high: state RESET_PLL, all counters 0. pll_rst_o=1, sys_rst_o=1, ready_o=0, fail_o=0; both *_cnt_o=0.
//  - clk_locked_i passes through a 2-flop synchronizer (lock_s) first. Lock changes reach the FSM 2 cycles later.
//  - All outputs are registered. Every state/counter change shows on the outputs in the cycle after the causing edge.
//  - RESET_PLL: pll_rst_o=1, sys_rst_o=1.
//    After PLL_RST_CYCLES cycles -> WAIT_LOCK. The timeout counter clears on entry.
//  - WAIT_LOCK: pll_rst_o=0, sys_rst_o=1. lock_s=1 -> STABLE, stable counter cleared.
//  - STABLE: pll_rst_o=0, sys_rst_o=1.
//    - lock_s=0 -> back to WAIT_LOCK; the timeout counter keeps running.
//    - LOCK_STABLE_CYCLES consecutive lock_s=1 -> RUN.
//  - Timeout: the counter runs through WAIT_LOCK and STABLE and reaches LOCK_TIMEOUT_CYCLES.
//    - retry_cnt_o increments.
//    - New value < MAX_RETRIES -> RESET_PLL; otherwise -> FAILED.
//    - Timeout has priority over the STABLE->RUN transition in the same cycle.
//  - RUN: pll_rst_o=0, sys_rst_o=0, ready_o=1.
//    - lock_s=0 -> RESET_PLL. sys_rst_o reasserts on the next edge; lock_loss_cnt_o increments, saturating.
//    - retry_cnt_o is not incremented and not cleared.
//  - FAILED: pll_rst_o=1, sys_rst_o=1, fail_o=1. Sticky until soft_rst_req_i or rst_in.
//  - soft_rst_req_i, any state: -> RESET_PLL, retry_cnt_o cleared, lock_loss_cnt_o kept.
//    - It has priority over every other transition in that cycle.
//    - A request while already in RESET_PLL restarts the PLL_RST_CYCLES count.
//  - rst_in mid-operation: immediate asynchronous return to reset values.
//    The synchronizer flops also reset, to 0.
//  - Counter widths: $clog2 of each limit + 1. Comparisons are exact (==). No wrap is reachable.
// STRUCTURE
//  - Package eth_clk_pkg:
//    - typedef enum logic [2:0] pll_seq_st_t {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAILED}.
//    - localparam LOCK_LOSS_CNT_W = 8.
//  - Sub-module cdc_sync_2ff: 2-flop synchronizer with async active-high reset, reset value parameterized.
//  - Remainder: one FSM plus three counters (phase, timeout, stable) in this module.
// TESTING (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
//  1. Release rst_in, raise lock at cycle 10 -> pll_rst_o low after 4 cycles; sys_rst_o low, ready_o high at cycle 10+2+8+1.
//  2. Lock glitches low 1 cycle inside STABLE -> stable count restarts; RUN reached 8 cycles after the glitch clears.
//  3. Lock never asserted -> two timeouts, retry_cnt_o 1 then 2; fail_o=1 with pll_rst_o=1 and sys_rst_o=1, held.
//  4. In RUN, drop lock -> sys_rst_o=1 within 3 cycles, lock_loss_cnt_o=1; relock -> RUN again, retry_cnt_o unchanged.
//  5. In FAILED, pulse soft_rst_req_i -> RESET_PLL, retry_cnt_o=0, fail_o=0; normal lock sequence completes.
//  6. Assert rst_in in STABLE and in RUN -> all outputs at reset values before the next edge; a 256th lock loss leaves lock_loss_cnt_o at 255.

Source files
------------

// File: rtl/eth_clk_pkg.sv
// rtl/eth_clk_pkg.sv - shared types for the PLL/system-reset sequencer
package eth_clk_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } pll_seq_st_t;

    localparam int LOCK_LOSS_CNT_W = 8;

endpackage

// File: rtl/cdc_sync_2ff.sv
// rtl/cdc_sync_2ff.sv - two-flop single-bit synchronizer with async reset
module cdc_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset/lock sequencer driving the system reset
module pll_rst_seq
    import eth_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               clk_locked_i,
    input  logic                               soft_rst_req_i,
    output logic                               pll_rst_o,
    output logic                               sys_rst_o,
    output logic                               ready_o,
    output logic                               fail_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
    output logic [LOCK_LOSS_CNT_W-1:0]         lock_loss_cnt_o,
    output logic [2:0]                         state_o
);

    localparam int PH_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int SB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int RT_W = $clog2(MAX_RETRIES + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PLL_RST_CYCLES - 1);
    localparam logic [SB_W-1:0] SB_LAST = SB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

    logic              lock_s;
    pll_seq_st_t       st;
    pll_seq_st_t       nxt;
    logic [PH_W-1:0]   phase_cnt;
    logic [SB_W-1:0]   stab_cnt;
    logic [TO_W-1:0]   tmo_cnt;
    logic [RT_W-1:0]   retry_inc;
    logic              locking;
    logic              tmo_hit;
    logic              timeout_evt;
    logic              loss_evt;

    cdc_sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (clk_locked_i),
        .q   (lock_s)
    );

    // The timeout window spans WAIT_LOCK and STABLE together, so a flapping
    // lock cannot hold the sequencer in those states forever.
    assign locking     = (st == WAIT_LOCK) || (st == STABLE);
    assign tmo_hit     = locking && (tmo_cnt == TO_LAST);
    assign retry_inc   = retry_cnt_o + 1'b1;
    assign timeout_evt = !soft_rst_req_i && tmo_hit;
    assign loss_evt    = !soft_rst_req_i && (st == RUN) && !lock_s;

    always_comb begin
        nxt = st;
        if (soft_rst_req_i) begin
            nxt = RESET_PLL;
        end else begin
            case (st)
                RESET_PLL: if (phase_cnt == PH_LAST) nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (tmo_hit)     nxt = (retry_inc == RT_MAX) ? FAILED : RESET_PLL;
                    else if (lock_s) nxt = STABLE;
                end
                STABLE: begin
                    if (tmo_hit)                nxt = (retry_inc == RT_MAX) ? FAILED : RESET_PLL;
                    else if (!lock_s)           nxt = WAIT_LOCK;
                    else if (stab_cnt == SB_LAST) nxt = RUN;
                end
                RUN:     if (!lock_s) nxt = RESET_PLL;
                FAILED:  nxt = FAILED;
                default: nxt = RESET_PLL;
            endcase
        end
    end

    // Outputs decode the next state so they change together with the state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            st              <= RESET_PLL;
            phase_cnt       <= '0;
            stab_cnt        <= '0;
            tmo_cnt         <= '0;
            retry_cnt_o     <= '0;
            lock_loss_cnt_o <= '0;
            pll_rst_o       <= 1'b1;
            sys_rst_o       <= 1'b1;
            ready_o         <= 1'b0;
            fail_o          <= 1'b0;
            state_o         <= RESET_PLL;
        end else begin
            st        <= nxt;
            phase_cnt <= (st == RESET_PLL && nxt == RESET_PLL && !soft_rst_req_i)
                         ? phase_cnt + 1'b1 : '0;
            tmo_cnt   <= (locking && (nxt == WAIT_LOCK || nxt == STABLE))
                         ? tmo_cnt + 1'b1 : '0;
            stab_cnt  <= (st == STABLE && nxt == STABLE) ? stab_cnt + 1'b1 : '0;

            if (soft_rst_req_i)   retry_cnt_o <= '0;
            else if (timeout_evt) retry_cnt_o <= retry_inc;

            if (loss_evt && lock_loss_cnt_o != '1)
                lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;

            pll_rst_o <= (nxt == RESET_PLL) || (nxt == FAILED);
            sys_rst_o <= (nxt != RUN);
            ready_o   <= (nxt == RUN);
            fail_o    <= (nxt == FAILED);
            state_o   <= nxt;
        end
    end

endmodule
